// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives all four (a,b) operand combinations to an
// external basic-gate stage, holds each vector for SETTLE cycles, then
// compares the returned 7-bit gate results against the ideal truth table.
// Mismatches are counted per vector (err_count, fail_vec) and per gate
// output (fail_mask). Every output comes from a register or is decoded
// from registered state only.
//
// Handshake: start is level-sampled in IDLE/DONE. busy is high for exactly
// 4*SETTLE cycles per sweep. done stays high until the next accepted start
// or reset, and pass is only meaningful (and only ever high) with done.
module gate_vector_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [6:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] vec_q, vec_d;
  logic [6:0] mask_q, mask_d;
  logic [6:0] exp_y;
  logic [6:0] diff;

  // Ideal gate results per vector index, bit order {XNOR,NOR,NAND,XOR,NOT a,OR,AND}.
  always_comb begin
    exp_y = 7'h74;
    case (idx_q)
      2'd0: exp_y = 7'h74;
      2'd1: exp_y = 7'h1E;
      2'd2: exp_y = 7'h1A;
      2'd3: exp_y = 7'h43;
      default: exp_y = 7'h74;
    endcase
    diff = y_in ^ exp_y;
  end

  // Next-state logic: sweep sequencing, settle countdown and result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT;
          idx_d   = 2'd0;
          cnt_d   = RELOAD;
          err_d   = 3'd0;
          vec_d   = 4'd0;
          mask_d  = 7'd0;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (diff != 7'd0) begin
            // At most four vectors per sweep, so saturating at 4 never loses a count.
            if (err_q != 3'd4) begin
              err_d = err_q + 3'd1;
            end
            vec_d[idx_q] = 1'b1;
            mask_d       = mask_q | diff;
          end
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over start and any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      vec_q   <= 4'd0;
      mask_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
    end
  end

  assign busy      = (state_q == WAIT);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 3'd0);
  assign a         = busy && idx_q[1];
  assign b         = busy && idx_q[0];
  assign err_count = err_q;
  assign fail_vec  = vec_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (SETTLE=2 and SETTLE=1), each
// fed by a behavioural gate stage that can be correct or faulted. Expected
// sweep results come from a truth-table reference and are queued at start;
// a negedge monitor pops and compares them when done rises.
module tb_gate_vector_checker;

  localparam int S0 = 2;
  localparam int S1 = 1;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       start0, start1;
  logic       a0, b0, a1, b1;
  logic [6:0] y0, y1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] vec0, vec1;
  logic [6:0] mask0, mask1;

  int          mode0, mode1;
  logic [27:0] flips0, flips1;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: {err_count, fail_vec, fail_mask}
  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];

  int   wait_cnt[2];
  logic done_prev[2];

  gate_vector_checker #(.SETTLE(S0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(vec0), .fail_mask(mask0)
  );

  gate_vector_checker #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(vec1), .fail_mask(mask1)
  );

  // Ideal gates, bit order {XNOR,NOR,NAND,XOR,NOT a,OR,AND}
  function automatic logic [6:0] gates(input logic ga, input logic gb);
    gates = {~(ga ^ gb), ~(ga | gb), ~(ga & gb), ga ^ gb, ~ga, ga | gb, ga & gb};
  endfunction

  // Downstream gate stage: 0 correct, 1 NOT stuck at 0, 2 swapped XOR/NAND/NOR, 3 random flips
  function automatic logic [6:0] model(input int md, input logic [27:0] fl,
                                       input logic ma, input logic mb);
    logic [6:0] t;
    int         i;
    t = gates(ma, mb);
    i = {30'd0, ma, mb};
    case (md)
      1: model = t & 7'b1111011;
      2: model = {t[6], t[3], t[5], t[4], t[2:0]};
      3: model = t ^ fl[i*7 +: 7];
      default: model = t;
    endcase
  endfunction

  // Reference result of one full sweep
  function automatic logic [13:0] ref_sweep(input int md, input logic [27:0] fl);
    int         e;
    logic [3:0] v;
    logic [6:0] m;
    logic [6:0] d;
    e = 0; v = '0; m = '0;
    for (int i = 0; i < 4; i++) begin
      d = model(md, fl, (i / 2) == 1, (i % 2) == 1) ^ gates((i / 2) == 1, (i % 2) == 1);
      if (d != 7'd0) begin
        e++;
        v[i] = 1'b1;
        m = m | d;
      end
    end
    ref_sweep = {3'(e), v, m};
  endfunction

  always_comb y0 = model(mode0, flips0, a0, b0);
  always_comb y1 = model(mode1, flips1, a1, b1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for one instance
  task automatic mon(input int k, input logic bz, input logic dn, input logic ps,
                     input logic ma, input logic mb, input logic [2:0] er,
                     input logic [3:0] vc, input logic [6:0] mk);
    int          settle;
    logic [13:0] e;
    settle = (k == 0) ? S0 : S1;
    if (bz) begin
      check($sformatf("ab_seq%0d", k), {30'd0, ma, mb}, wait_cnt[k] / settle);
      wait_cnt[k]++;
    end
    if (!dn) check($sformatf("pass_low%0d", k), ps, 0);
    if (dn && !done_prev[k]) begin
      check($sformatf("wait_cycles%0d", k), wait_cnt[k], 4 * settle);
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done%0d: got done with no sweep expected", k);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("err_count%0d", k), er, e[13:11]);
        check($sformatf("fail_vec%0d", k), vc, e[10:7]);
        check($sformatf("fail_mask%0d", k), mk, e[6:0]);
        check($sformatf("pass%0d", k), ps, e[13:11] == 3'd0);
      end
    end
    if (!bz) wait_cnt[k] = 0;
    done_prev[k] = dn;
  endtask

  // Monitor process, sampling on the inactive edge
  always @(negedge clk) begin
    mon(0, busy0, done0, pass0, a0, b0, err0, vec0, mask0);
    mon(1, busy1, done1, pass1, a1, b1, err1, vec1, mask1);
  end

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!((k == 0) ? done0 : done1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout%0d: got no done within 200 cycles", k);
    end
  endtask

  task automatic sweep(input int k);
    if (k == 0) begin
      exp_q0.push_back(ref_sweep(mode0, flips0));
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end else begin
      exp_q1.push_back(ref_sweep(mode1, flips1));
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    wait_done(k);
  endtask

  function automatic logic [27:0] rand_flips();
    logic [27:0] f;
    for (int v = 0; v < 4; v++) begin
      f[v*7 +: 7] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
    end
    rand_flips = f;
  endfunction

  // Driver
  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode0 = 0; mode1 = 0; flips0 = '0; flips1 = '0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    done_prev[0] = 1'b0; done_prev[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags0", {busy0, done0, pass0, a0, b0}, 0);
    check("rst_res0", {err0, vec0, mask0}, 0);
    check("rst_flags1", {busy1, done1, pass1, a1, b1}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed gate-stage faults on the SETTLE=2 instance
    mode0 = 0; sweep(0);
    mode0 = 1; sweep(0);
    mode0 = 2; sweep(0);

    // Start held high through a sweep: no restart while busy, restart from DONE
    mode0 = 0;
    exp_q0.push_back(ref_sweep(mode0, flips0));
    exp_q0.push_back(ref_sweep(mode0, flips0));
    start0 = 1'b1;
    @(negedge clk);
    wait_done(0);
    @(negedge clk);
    check("restart_busy", busy0, 1);
    check("restart_done", done0, 0);
    start0 = 1'b0;
    wait_done(0);

    // Reset during the third WAIT cycle with partial errors accumulated
    mode0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy0, done0, pass0, a0, b0}, 0);
    check("midrst_err", err0, 0);
    check("midrst_vec", vec0, 0);
    check("midrst_mask", mask0, 0);
    rst = 1'b0;
    mode0 = 0;
    @(negedge clk);
    sweep(0);

    // SETTLE=1 instance
    mode1 = 0; sweep(1);
    mode1 = 1; sweep(1);
    mode1 = 2; sweep(1);

    // Randomized gate-stage faults on both instances
    for (int r = 0; r < 8; r++) begin
      mode0 = 3; flips0 = rand_flips();
      sweep(0);
      mode1 = 3; flips1 = rand_flips();
      sweep(1);
    end

    repeat (5) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
